ula_controle: RTL and testbench

- Issuing side of the ULA operand/result interface: owns the `Operacao`/`in1`/`in2` wires into the ULA and consumes `saida`/`saida_comp`.
- Holds a 4x8 signed operand register bank.
- Accepts one instruction at a time on a valid/ready port, drives the ULA, captures the result into the bank, and returns it on a valid/ready response port.
- Sits between instruction sequencing and the combinational ULA in the datapath.

---
 rtl/ula_pkg.sv | 26 ++
 rtl/banco_regs.sv | 40 ++++
 rtl/ula_controle.sv | 159 +++++++++++++++
 tb/tb_ula_controle.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
//==============================================================================
// Module      : ula_pkg
// Description : Shared opcodes, FSM states and default widths for ula_controle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ula_pkg;

    localparam int LARGURA_PADRAO = 8;
    localparam int NREGS_PADRAO   = 4;

    localparam logic [1:0] OP_SOMA_U = 2'd0;
    localparam logic [1:0] OP_SOMA_S = 2'd1;
    localparam logic [1:0] OP_MULT_S = 2'd2;
    localparam logic [1:0] OP_RESERV = 2'd3;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EMITE    = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

endpackage : ula_pkg

`default_nettype wire

// File: rtl/banco_regs.sv
//==============================================================================
// Module      : banco_regs
// Description : Operand register bank, one write port, two combinational reads.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module banco_regs #(
    parameter int LARGURA = 8,
    parameter int NREGS   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we_i,
    input  logic [$clog2(NREGS)-1:0]   wa_i,
    input  logic [LARGURA-1:0]         wd_i,
    input  logic [$clog2(NREGS)-1:0]   ra1_i,
    output logic [LARGURA-1:0]         rd1_o,
    input  logic [$clog2(NREGS)-1:0]   ra2_i,
    output logic [LARGURA-1:0]         rd2_o
);

    logic [LARGURA-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = regs_q[ra1_i];
    assign rd2_o = regs_q[ra2_i];

endmodule : banco_regs

`default_nettype wire

// File: rtl/ula_controle.sv
//==============================================================================
// Module      : ula_controle
// Description : Issues instructions to the combinational ULA, writes results
//               back into the operand bank and returns them on a response port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ula_controle
    import ula_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int NREGS   = NREGS_PADRAO
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic                       instr_tipo,
    input  logic [1:0]                 instr_op,
    input  logic [$clog2(NREGS)-1:0]   instr_rd,
    input  logic [$clog2(NREGS)-1:0]   instr_rs1,
    input  logic [$clog2(NREGS)-1:0]   instr_rs2,
    input  logic [LARGURA-1:0]         instr_imm,
    output logic [1:0]                 Operacao,
    output logic [LARGURA-1:0]         in1,
    output logic [LARGURA-1:0]         in2,
    input  logic [LARGURA-1:0]         saida,
    input  logic                       saida_comp,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [LARGURA-1:0]         resp_dado,
    output logic                       resp_comp,
    output logic                       resp_erro
);

    localparam int AW = $clog2(NREGS);

    estado_t            estado_q, estado_d;
    logic [1:0]         operacao_q, operacao_d;
    logic [LARGURA-1:0] in1_q, in1_d;
    logic [LARGURA-1:0] in2_q, in2_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic [LARGURA-1:0] dado_q, dado_d;
    logic               comp_q, comp_d;
    logic               erro_q, erro_d;

    logic               w_we;
    logic [AW-1:0]      w_wa;
    logic [LARGURA-1:0] w_wd;
    logic [LARGURA-1:0] w_rdata1;
    logic [LARGURA-1:0] w_rdata2;

    banco_regs #(
        .LARGURA (LARGURA),
        .NREGS   (NREGS)
    ) u_banco (
        .clk   (clk),
        .reset (reset),
        .we_i  (w_we),
        .wa_i  (w_wa),
        .wd_i  (w_wd),
        .ra1_i (instr_rs1),
        .rd1_o (w_rdata1),
        .ra2_i (instr_rs2),
        .rd2_o (w_rdata2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            operacao_q <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            rd_q       <= '0;
            dado_q     <= '0;
            comp_q     <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            operacao_q <= operacao_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            rd_q       <= rd_d;
            dado_q     <= dado_d;
            comp_q     <= comp_d;
            erro_q     <= erro_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        operacao_d = operacao_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        rd_d       = rd_q;
        dado_d     = dado_q;
        comp_d     = comp_q;
        erro_d     = erro_q;
        w_we       = 1'b0;
        w_wa       = instr_rd;
        w_wd       = instr_imm;

        case (estado_q)
            OCIOSO: begin
                if (instr_valid) begin
                    if (instr_tipo) begin
                        w_we     = 1'b1;
                        dado_d   = instr_imm;
                        comp_d   = 1'b0;
                        erro_d   = 1'b0;
                        estado_d = RESPOSTA;
                    end else if (instr_op == OP_RESERV) begin
                        dado_d   = '0;
                        comp_d   = 1'b0;
                        erro_d   = 1'b1;
                        estado_d = RESPOSTA;
                    end else begin
                        // Operands are sampled here, so rd may alias rs1/rs2.
                        operacao_d = instr_op;
                        in1_d      = w_rdata1;
                        in2_d      = w_rdata2;
                        rd_d       = instr_rd;
                        estado_d   = EMITE;
                    end
                end
            end
            EMITE: begin
                w_we     = 1'b1;
                w_wa     = rd_q;
                w_wd     = saida;
                dado_d   = saida;
                comp_d   = saida_comp;
                erro_d   = 1'b0;
                estado_d = RESPOSTA;
            end
            RESPOSTA: begin
                if (resp_ready) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign instr_ready = (estado_q == OCIOSO);
    assign resp_valid  = (estado_q == RESPOSTA);
    assign Operacao    = operacao_q;
    assign in1         = in1_q;
    assign in2         = in2_q;
    assign resp_dado   = dado_q;
    assign resp_comp   = comp_q;
    assign resp_erro   = erro_q;

endmodule : ula_controle

`default_nettype wire

// File: tb/tb_ula_controle.sv
//==============================================================================
// Module      : tb_ula_controle
// Description : Directed bench for ula_controle with a reference ULA and model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ula_controle;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid, instr_ready, instr_tipo;
    logic [1:0] instr_op, instr_rd, instr_rs1, instr_rs2;
    logic [7:0] instr_imm;
    logic [1:0] Operacao;
    logic [7:0] in1, in2, saida;
    logic       saida_comp;
    logic       resp_valid, resp_ready, resp_comp, resp_erro;
    logic [7:0] resp_dado;

    always #5 clk = ~clk;

    ula_controle #(.LARGURA(8), .NREGS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_tipo  (instr_tipo),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .Operacao    (Operacao),
        .in1         (in1),
        .in2         (in2),
        .saida       (saida),
        .saida_comp  (saida_comp),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_dado   (resp_dado),
        .resp_comp   (resp_comp),
        .resp_erro   (resp_erro)
    );

    // Reference ULA: comp flags carry (unsigned add) or signed overflow.
    logic [8:0]  soma9;
    logic [7:0]  soma8;
    logic [15:0] prod;
    always_comb begin
        soma9      = {1'b0, in1} + {1'b0, in2};
        soma8      = in1 + in2;
        prod       = $signed({{8{in1[7]}}, in1}) * $signed({{8{in2[7]}}, in2});
        saida      = 8'h00;
        saida_comp = 1'b0;
        case (Operacao)
            2'd0: begin saida = soma9[7:0]; saida_comp = soma9[8]; end
            2'd1: begin
                saida      = soma8;
                saida_comp = (in1[7] == in2[7]) && (soma8[7] != in1[7]);
            end
            2'd2: begin saida = prod[7:0]; saida_comp = (prod != {{8{prod[7]}}, prod[7:0]}); end
            default: begin saida = 8'h00; saida_comp = 1'b0; end
        endcase
    end

    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 0;
    logic [7:0] mbank [4];
    logic       exp_ready, exp_valid, exp_comp, exp_erro;
    logic [1:0] exp_op;
    logic [7:0] exp_in1, exp_in2, exp_dado;
    logic [7:0] got_dado;
    logic       got_erro;

    task automatic chk(input string nome, input logic [7:0] atual, input logic [7:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_ready", {7'd0, instr_ready}, {7'd0, exp_ready});
            chk("resp_valid",  {7'd0, resp_valid},  {7'd0, exp_valid});
            chk("Operacao",    {6'd0, Operacao},    {6'd0, exp_op});
            chk("in1",         in1,                 exp_in1);
            chk("in2",         in2,                 exp_in2);
            chk("resp_dado",   resp_dado,           exp_dado);
            chk("resp_comp",   {7'd0, resp_comp},   {7'd0, exp_comp});
            chk("resp_erro",   {7'd0, resp_erro},   {7'd0, exp_erro});
            if (resp_valid) begin
                got_dado = resp_dado;
                got_erro = resp_erro;
            end
        end
    end

    function automatic void ula_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] r, output logic c);
        int ua, ub, sa, sb, t;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        case (op)
            2'd0: begin t = ua + ub; r = 8'(t % 256); c = (t > 255); end
            2'd1: begin t = sa + sb; r = 8'(t); c = (t > 127) || (t < -128); end
            2'd2: begin t = sa * sb; r = 8'(t); c = (t > 127) || (t < -128); end
            default: begin r = 8'h00; c = 1'b0; end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mbank[i] = 8'h00;
        exp_ready = 1'b1; exp_valid = 1'b0; exp_op = 2'd0;
        exp_in1 = 8'h00; exp_in2 = 8'h00;
        exp_dado = 8'h00; exp_comp = 1'b0; exp_erro = 1'b0;
    endtask

    task automatic issue(input bit tipo, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                         input int hold, input bit poke, input bit abort);
        logic [7:0] r;
        logic       c;
        instr_valid = 1'b1; instr_tipo = tipo; instr_op = op;
        instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        step();
        instr_valid = 1'b0;
        exp_ready   = 1'b0;
        if (tipo) begin
            mbank[rd] = imm;
            exp_dado = imm; exp_comp = 1'b0; exp_erro = 1'b0; exp_valid = 1'b1;
        end else if (op == 2'd3) begin
            exp_dado = 8'h00; exp_comp = 1'b0; exp_erro = 1'b1; exp_valid = 1'b1;
        end else begin
            exp_op = op; exp_in1 = mbank[rs1]; exp_in2 = mbank[rs2];
            if (abort) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                model_reset();
                return;
            end
            step();
            ula_ref(exp_op, exp_in1, exp_in2, r, c);
            mbank[rd] = r;
            exp_dado = r; exp_comp = c; exp_erro = 1'b0; exp_valid = 1'b1;
        end
        for (int k = 0; k < hold; k++) begin
            resp_ready = 1'b0;
            if (poke) begin
                instr_valid = 1'b1; instr_tipo = 1'b1; instr_rd = 2'd3; instr_imm = 8'h55;
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        exp_valid  = 1'b0;
        exp_ready  = 1'b1;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr_tipo = 1'b0; instr_op = 2'd0;
        instr_rd = 2'd0; instr_rs1 = 2'd0; instr_rs2 = 2'd0; instr_imm = 8'h00;
        resp_ready = 1'b0; got_dado = 8'h00; got_erro = 1'b0;
        step();
        model_reset();
        chk_en = 1;
        step();
        reset = 1'b0;
        step();

        issue(1, 2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 0, 0, 0);
        issue(1, 2'd0, 2'd1, 2'd0, 2'd0, 8'h01, 0, 0, 0);
        issue(0, 2'd0, 2'd2, 2'd0, 2'd1, 8'h00, 0, 0, 0);
        chk("pin_add_u", got_dado, 8'd1);
        chk("pin_bank_r2", mbank[2], 8'd1);

        issue(1, 2'd0, 2'd0, 2'd0, 2'd0, 8'hFF, 0, 0, 0);
        issue(0, 2'd1, 2'd3, 2'd0, 2'd1, 8'h00, 1, 0, 0);
        chk("pin_add_s", got_dado, 8'd0);
        chk("pin_add_s_erro", {7'd0, got_erro}, 8'd0);

        issue(1, 2'd0, 2'd0, 2'd0, 2'd0, 8'h02, 0, 0, 0);
        issue(1, 2'd0, 2'd1, 2'd0, 2'd0, 8'h02, 0, 0, 0);
        issue(0, 2'd2, 2'd0, 2'd0, 2'd1, 8'h00, 0, 0, 0);
        chk("pin_mult_4", got_dado, 8'd4);
        issue(0, 2'd2, 2'd0, 2'd0, 2'd0, 8'h00, 0, 0, 0);
        chk("pin_mult_16", got_dado, 8'd16);
        issue(1, 2'd0, 2'd2, 2'd0, 2'd0, 8'h40, 0, 0, 0);
        issue(0, 2'd2, 2'd2, 2'd2, 2'd2, 8'h00, 0, 0, 0);
        chk("pin_mult_wrap", got_dado, 8'd0);

        issue(0, 2'd3, 2'd1, 2'd0, 2'd0, 8'h00, 0, 0, 0);
        chk("pin_reserv_erro", {7'd0, got_erro}, 8'd1);
        chk("pin_reserv_dado", got_dado, 8'd0);
        issue(0, 2'd0, 2'd3, 2'd1, 2'd3, 8'h00, 0, 0, 0);
        chk("pin_r1_unchanged", got_dado, 8'd2);

        issue(1, 2'd0, 2'd1, 2'd0, 2'd0, 8'h07, 3, 1, 0);
        issue(1, 2'd0, 2'd3, 2'd0, 2'd0, 8'h55, 0, 0, 0);
        chk("pin_after_hold", got_dado, 8'h55);
        issue(0, 2'd0, 2'd0, 2'd1, 2'd3, 8'h00, 2, 0, 0);
        chk("pin_hold_sum", got_dado, 8'h5C);

        issue(0, 2'd0, 2'd1, 2'd3, 2'd3, 8'h00, 0, 0, 1);
        step();
        issue(0, 2'd0, 2'd0, 2'd1, 2'd3, 8'h00, 0, 0, 0);
        chk("pin_after_abort", got_dado, 8'd0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ula_controle

`default_nettype wire
